// File: rtl/qdr_rr_arbiter.sv
// qdr_rr_arbiter
// Four-port round-robin arbiter in front of a single QDR controller.
// Each cycle at most one port's command is granted. Writes take two data
// beats on the controller side, so a write grant blocks further writes for
// the next cycle. Reads remember their port in a tag FIFO so returning read
// data can be steered back to the requester in issue order.
//
// Handshake: a port's request is in_wr_strb|in_rd_strb, held by the port
// until in_cmd_ack for that port is seen high in the same cycle; the command
// is accepted on that rising clk edge. A port presenting both strobes is
// treated as a write and its read strobe is ignored. Read returns have no
// back-pressure: out_rd_dvld is a one-cycle pulse that is forwarded
// immediately as in_rd_dvld[tag].
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   in_cmd_addr     4x32 packed per-port command address
//   in_wr_strb      per-port write request
//   in_rd_strb      per-port read request
//   in_wr_data      4xDW packed per-port write data
//   in_wr_be        4xBW packed per-port byte enables
//   in_cmd_ack      per-port command accepted this cycle
//   in_rd_dvld      per-port read data valid
//   in_rd_data      shared read data (pass-through of out_rd_data)
//   out_cmd_addr    address to the QDR controller
//   out_wr_strb     write command strobe to the controller
//   out_rd_strb     read command strobe to the controller
//   out_wr_data     write data (two beats per write)
//   out_wr_be       byte enables (two beats per write)
//   out_rd_dvld     read data valid from the controller
//   out_rd_data     read data from the controller
//   rd_outstanding  tag FIFO occupancy
//   rd_underflow    sticky: read data returned with no read outstanding
module qdr_rr_arbiter #(
  parameter int C_WIDE_DATA     = 0,
  parameter int MAX_OUTSTANDING = 16,
  localparam int DW = 36 * (1 + C_WIDE_DATA),
  localparam int BW = 4 * (1 + C_WIDE_DATA)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [127:0]    in_cmd_addr,
  input  logic [3:0]      in_wr_strb,
  input  logic [3:0]      in_rd_strb,
  input  logic [4*DW-1:0] in_wr_data,
  input  logic [4*BW-1:0] in_wr_be,
  output logic [3:0]      in_cmd_ack,
  output logic [3:0]      in_rd_dvld,
  output logic [DW-1:0]   in_rd_data,
  output logic [31:0]     out_cmd_addr,
  output logic            out_wr_strb,
  output logic            out_rd_strb,
  output logic [DW-1:0]   out_wr_data,
  output logic [BW-1:0]   out_wr_be,
  input  logic            out_rd_dvld,
  input  logic [DW-1:0]   out_rd_data,
  output logic [6:0]      rd_outstanding,
  output logic            rd_underflow
);

  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Arbitration state
  logic [1:0]    r_last_grant;
  logic          r_bubble;     // previous cycle granted a write
  logic [1:0]    r_beat_port;  // port of that write, for the second data beat

  // Read-tag FIFO
  logic [1:0]    r_tag_mem [MAX_OUTSTANDING];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [6:0]    r_count;
  logic          r_underflow;

  logic          w_full;
  logic          w_empty;
  logic [3:0]    w_elig;
  logic          w_grant_vld;
  logic [1:0]    w_grant_port;
  logic          w_grant_wr;
  logic          w_grant_rd;
  logic [1:0]    w_data_port;
  logic [1:0]    w_head;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == 7'(MAX_OUTSTANDING));
  assign w_empty = (r_count == 7'd0);
  assign w_head  = r_tag_mem[r_rd_ptr];

  // A port's command type is decided by wr_strb alone, so a port showing
  // both strobes during the write bubble waits rather than slipping a read in.
  // Reads are blocked on the registered full flag, independent of any pop.
  always_comb begin
    w_elig = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      if (in_wr_strb[p]) begin
        w_elig[p] = ~r_bubble;
      end else begin
        w_elig[p] = in_rd_strb[p] & ~w_full;
      end
    end
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    logic [1:0] v_idx;
    v_idx        = 2'd0;
    w_grant_vld  = 1'b0;
    w_grant_port = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      v_idx = r_last_grant + 2'(k);
      if (!w_grant_vld && w_elig[v_idx]) begin
        w_grant_vld  = 1'b1;
        w_grant_port = v_idx;
      end
    end
    if (rst) begin
      w_grant_vld  = 1'b0;
      w_grant_port = 2'd0;
    end
  end

  assign w_grant_wr = w_grant_vld & in_wr_strb[w_grant_port];
  assign w_grant_rd = w_grant_vld & ~in_wr_strb[w_grant_port];
  assign w_push     = w_grant_rd;
  assign w_pop      = out_rd_dvld & ~w_empty & ~rst;

  // First beat comes from the port being granted, second beat from the port
  // granted a write last cycle; port 0 is the idle default.
  always_comb begin
    w_data_port = 2'd0;
    if (w_grant_wr) begin
      w_data_port = w_grant_port;
    end else if (r_bubble) begin
      w_data_port = r_beat_port;
    end
  end

  always_comb begin
    out_cmd_addr = in_cmd_addr[31:0];
    out_wr_data  = in_wr_data[DW-1:0];
    out_wr_be    = in_wr_be[BW-1:0];
    for (int p = 0; p < 4; p++) begin
      if (w_grant_port == 2'(p)) begin
        out_cmd_addr = in_cmd_addr[p*32 +: 32];
      end
      if (w_data_port == 2'(p)) begin
        out_wr_data = in_wr_data[p*DW +: DW];
        out_wr_be   = in_wr_be[p*BW +: BW];
      end
    end
  end

  assign in_cmd_ack     = w_grant_vld ? (4'b0001 << w_grant_port) : 4'b0000;
  assign out_wr_strb    = w_grant_wr;
  assign out_rd_strb    = w_grant_rd;
  assign in_rd_dvld     = w_pop ? (4'b0001 << w_head) : 4'b0000;
  assign in_rd_data     = out_rd_data;
  assign rd_outstanding = r_count;
  assign rd_underflow   = r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 2'd3;
      r_bubble     <= 1'b0;
      r_beat_port  <= 2'd0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= 7'd0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_grant_vld) begin
        r_last_grant <= w_grant_port;
      end
      r_bubble <= w_grant_wr;
      if (w_grant_wr) begin
        r_beat_port <= w_grant_port;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 7'd1;
        2'b01:   r_count <= r_count - 7'd1;
        default: r_count <= r_count;
      endcase
      if (out_rd_dvld && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_grant_port;
    end
  end

endmodule

// File: tb/tb_qdr_rr_arbiter.sv
// Bench for qdr_rr_arbiter (MAX_OUTSTANDING=4 so the full condition is
// reachable in a few cycles). A behavioural model (tag queue, last grant,
// write-bubble flag) predicts every output each cycle; directed table rows
// add hand-derived expectations, followed by reset/underflow sequences and
// a randomized run.
module tb_qdr_rr_arbiter;
  localparam int DW  = 36;
  localparam int BW  = 4;
  localparam int MAX = 4;

  logic            clk;
  logic            rst;
  logic [127:0]    in_cmd_addr;
  logic [3:0]      in_wr_strb;
  logic [3:0]      in_rd_strb;
  logic [4*DW-1:0] in_wr_data;
  logic [4*BW-1:0] in_wr_be;
  logic [3:0]      in_cmd_ack;
  logic [3:0]      in_rd_dvld;
  logic [DW-1:0]   in_rd_data;
  logic [31:0]     out_cmd_addr;
  logic            out_wr_strb;
  logic            out_rd_strb;
  logic [DW-1:0]   out_wr_data;
  logic [BW-1:0]   out_wr_be;
  logic            out_rd_dvld;
  logic [DW-1:0]   out_rd_data;
  logic [6:0]      rd_outstanding;
  logic            rd_underflow;

  qdr_rr_arbiter #(.C_WIDE_DATA(0), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .in_cmd_addr(in_cmd_addr), .in_wr_strb(in_wr_strb), .in_rd_strb(in_rd_strb),
    .in_wr_data(in_wr_data), .in_wr_be(in_wr_be),
    .in_cmd_ack(in_cmd_ack), .in_rd_dvld(in_rd_dvld), .in_rd_data(in_rd_data),
    .out_cmd_addr(out_cmd_addr), .out_wr_strb(out_wr_strb), .out_rd_strb(out_rd_strb),
    .out_wr_data(out_wr_data), .out_wr_be(out_wr_be),
    .out_rd_dvld(out_rd_dvld), .out_rd_data(out_rd_data),
    .rd_outstanding(rd_outstanding), .rd_underflow(rd_underflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  logic [1:0] exp_q[$];   // port IDs of reads in flight, oldest first
  int         m_last;
  bit         m_bubble;
  int         m_beat;
  bit         m_uf;

  int n_vec;
  int n_miss;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic randomize_payload();
    for (int p = 0; p < 4; p++) begin
      in_cmd_addr[p*32 +: 32] = $urandom;
      in_wr_data[p*DW +: 32]  = $urandom;
      in_wr_data[p*DW+32 +: 4] = 4'($urandom_range(0, 15));
      in_wr_be[p*BW +: BW]    = 4'($urandom_range(0, 15));
    end
    out_rd_data[31:0]  = $urandom;
    out_rd_data[35:32] = 4'($urandom_range(0, 15));
  endtask

  // One clock cycle: inputs are already driven; check mid-cycle against
  // the model (and optional hand-derived values), then advance the model.
  task automatic step(input bit use_tbl, input logic [3:0] t_ack,
                      input logic [3:0] t_rdv, input logic [6:0] t_out);
    int         g;
    int         dp;
    bit         gw;
    logic [3:0] e_ack;
    logic [3:0] e_rdv;
    #4;
    g = -1;
    if (!rst) begin
      for (int k = 1; k <= 4; k++) begin
        int p;
        bit el;
        p  = (m_last + k) % 4;
        el = in_wr_strb[p] ? !m_bubble : (in_rd_strb[p] && exp_q.size() < MAX);
        if (g < 0 && el) g = p;
      end
    end
    gw    = (g >= 0) && in_wr_strb[g];
    e_ack = (g >= 0) ? 4'(1 << g) : 4'b0000;
    e_rdv = (!rst && out_rd_dvld && exp_q.size() > 0) ? 4'(1 << exp_q[0]) : 4'b0000;

    chk("cmd_ack", 64'(in_cmd_ack), 64'(e_ack));
    chk("out_wr_strb", 64'(out_wr_strb), 64'(gw));
    chk("out_rd_strb", 64'(out_rd_strb), 64'((g >= 0) && !gw));
    chk("in_rd_dvld", 64'(in_rd_dvld), 64'(e_rdv));
    chk("rd_outstanding", 64'(rd_outstanding), 64'(exp_q.size()));
    chk("rd_underflow", 64'(rd_underflow), 64'(m_uf));
    chk("in_rd_data", 64'(in_rd_data), 64'(out_rd_data));
    if (g >= 0) chk("out_cmd_addr", 64'(out_cmd_addr), 64'(in_cmd_addr[g*32 +: 32]));
    if (!rst) begin
      dp = gw ? g : (m_bubble ? m_beat : 0);
      chk("out_wr_data", 64'(out_wr_data), 64'(in_wr_data[dp*DW +: DW]));
      chk("out_wr_be", 64'(out_wr_be), 64'(in_wr_be[dp*BW +: BW]));
    end
    if (use_tbl) begin
      chk("tbl_ack", 64'(in_cmd_ack), 64'(t_ack));
      chk("tbl_rd_dvld", 64'(in_rd_dvld), 64'(t_rdv));
      chk("tbl_outstanding", 64'(rd_outstanding), 64'(t_out));
    end

    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_last   = 3;
      m_bubble = 1'b0;
      m_uf     = 1'b0;
    end else begin
      if (out_rd_dvld) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else m_uf = 1'b1;
      end
      if (g >= 0 && !gw) exp_q.push_back(2'(g));
      if (g >= 0) m_last = g;
      m_bubble = gw;
      if (gw) m_beat = g;
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] w, input logic [3:0] rd, input logic dv);
    rst         = r;
    in_wr_strb  = w;
    in_rd_strb  = rd;
    out_rd_dvld = dv;
    randomize_payload();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] wr;
    logic [3:0] rd;
    logic       dv;
    logic [3:0] ack;
    logic [3:0] rdv;
    logic [6:0] outs;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic [3:0] wr, input logic [3:0] rd, input logic dv,
                              input logic [3:0] ack, input logic [3:0] rdv, input logic [6:0] outs);
    vec_t v;
    v.wr = wr; v.rd = rd; v.dv = dv; v.ack = ack; v.rdv = rdv; v.outs = outs;
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_miss = 0;
    m_last = 3;
    m_bubble = 1'b0;
    m_beat = 0;
    m_uf = 1'b0;

    // all ports read: 0,1,2,3 then FIFO full blocks reads until a return
    tbl[0]  = mk(4'b0000, 4'b1111, 1'b0, 4'b0001, 4'b0000, 7'd0);
    tbl[1]  = mk(4'b0000, 4'b1111, 1'b0, 4'b0010, 4'b0000, 7'd1);
    tbl[2]  = mk(4'b0000, 4'b1111, 1'b0, 4'b0100, 4'b0000, 7'd2);
    tbl[3]  = mk(4'b0000, 4'b1111, 1'b0, 4'b1000, 4'b0000, 7'd3);
    tbl[4]  = mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0001, 7'd4);
    tbl[5]  = mk(4'b0000, 4'b1111, 1'b0, 4'b0001, 4'b0000, 7'd3);
    tbl[6]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 7'd4);
    tbl[7]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0100, 7'd3);
    tbl[8]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1000, 7'd2);
    tbl[9]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0001, 7'd1);
    // writes on 1,2 with a read on 3: 1(W),3(R),2(W),3(R)
    tbl[10] = mk(4'b0110, 4'b1000, 1'b0, 4'b0010, 4'b0000, 7'd0);
    tbl[11] = mk(4'b0100, 4'b1000, 1'b0, 4'b1000, 4'b0000, 7'd0);
    tbl[12] = mk(4'b0100, 4'b1000, 1'b0, 4'b0100, 4'b0000, 7'd1);
    tbl[13] = mk(4'b0000, 4'b1000, 1'b0, 4'b1000, 4'b0000, 7'd1);
    tbl[14] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1000, 7'd2);
    tbl[15] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1000, 7'd1);
    // reads from 2,0,2 then returns with gaps
    tbl[16] = mk(4'b0000, 4'b0100, 1'b0, 4'b0100, 4'b0000, 7'd0);
    tbl[17] = mk(4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0000, 7'd1);
    tbl[18] = mk(4'b0000, 4'b0100, 1'b0, 4'b0100, 4'b0000, 7'd2);
    tbl[19] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 7'd3);
    tbl[20] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0100, 7'd3);
    tbl[21] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 7'd2);
    tbl[22] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0001, 7'd2);
    tbl[23] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 7'd1);
    tbl[24] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 7'd1);
    tbl[25] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0100, 7'd1);

    // ---------------- reset ----------------
    drive(1'b1, 4'b1111, 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b1, 4'b1111, 4'b1111, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 7'd0);
    drive(1'b1, 4'b0000, 4'b1111, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 7'd0);

    // ---------------- table ----------------
    for (int i = 0; i < 26; i++) begin
      drive(1'b0, tbl[i].wr, tbl[i].rd, tbl[i].dv);
      step(1'b1, tbl[i].ack, tbl[i].rdv, tbl[i].outs);
    end

    // ---------------- underflow on empty FIFO ----------------
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 7'd0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 7'd0);
    chk("underflow_set", 64'(rd_underflow), 64'd1);
    drive(1'b0, 4'b0010, 4'b0001, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 7'd0);
    chk("underflow_sticky", 64'(rd_underflow), 64'd1);

    // ---------------- reads in flight across a reset ----------------
    drive(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 7'd0);
    chk("underflow_cleared", 64'(rd_underflow), 64'd0);
    drive(1'b0, 4'b0000, 4'b0011, 1'b0);
    step(1'b1, 4'b0001, 4'b0000, 7'd0);
    drive(1'b0, 4'b0000, 4'b0010, 1'b0);
    step(1'b1, 4'b0010, 4'b0000, 7'd1);
    drive(1'b1, 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 7'd2);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 7'd0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 7'd0);
    chk("underflow_after_rst", 64'(rd_underflow), 64'd1);

    // ---------------- randomized run ----------------
    drive(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 7'd0);
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 149) == 0),
            4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0));
      step(1'b0, 4'b0000, 4'b0000, 7'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
